// File: rtl/seq_match_sched.sv
// Serial pattern matcher fed from a word-wide valid/ready stream.
// Words are shifted out MSB-first, one bit per clock, and scanned for a programmable pattern.
module seq_match_sched #(
  parameter int WORD_W  = 8,
  parameter int PAT_MAX = 8,
  parameter int CNT_W   = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cfg_load,
  input  logic [PAT_MAX-1:0] cfg_pattern,
  input  logic [3:0]         cfg_len,
  input  logic               cfg_overlap,
  input  logic [CNT_W-1:0]   cfg_limit,
  input  logic               in_valid,
  input  logic [WORD_W-1:0]  in_data,
  output logic               in_ready,
  output logic               match_pulse,
  output logic [CNT_W-1:0]   match_count,
  output logic               busy,
  output logic               done,
  output logic               cfg_err
);

  localparam int IDX_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;

  localparam logic [1:0] S_UNCFG  = 2'd0;
  localparam logic [1:0] S_ACCEPT = 2'd1;
  localparam logic [1:0] S_SHIFT  = 2'd2;
  localparam logic [1:0] S_HALT   = 2'd3;

  logic [1:0]         state;
  logic [WORD_W-1:0]  word;
  logic [IDX_W-1:0]   idx;
  logic [PAT_MAX-1:0] hist;
  logic [3:0]         fill;
  logic [PAT_MAX-1:0] pat;
  logic [3:0]         len;
  logic               ovl;
  logic [CNT_W-1:0]   lim;

  logic               cfg_ok;
  logic               bit_in;
  logic [PAT_MAX-1:0] hist_n;
  logic [3:0]         fill_n;
  logic [PAT_MAX-1:0] mask;
  logic               hit;
  logic [CNT_W-1:0]   cnt_inc;
  logic               lim_hit;
  logic               last_bit;

  assign cfg_ok   = (cfg_len != 4'd0) && (cfg_len <= 4'(PAT_MAX));
  // The word register shifts left each bit, so the bit under scan is always its MSB.
  assign bit_in   = word[WORD_W-1];
  assign hist_n   = {hist[PAT_MAX-2:0], bit_in};
  assign fill_n   = (fill >= 4'(PAT_MAX)) ? 4'(PAT_MAX) : fill + 4'd1;
  assign cnt_inc  = (match_count == {CNT_W{1'b1}}) ? match_count : match_count + CNT_W'(1);
  assign last_bit = (idx == IDX_W'(WORD_W - 1));

  always_comb begin
    mask = '0;
    for (int i = 0; i < PAT_MAX; i++)
      mask[i] = (4'(i) < len);
  end

  assign hit     = (fill_n >= len) && (((hist_n ^ pat) & mask) == '0);
  assign lim_hit = hit && (lim != '0) && (cnt_inc == lim);

  assign in_ready = (state == S_ACCEPT);
  assign busy     = (state == S_SHIFT);
  assign done     = (state == S_HALT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_UNCFG;
      word        <= '0;
      idx         <= '0;
      hist        <= '0;
      fill        <= '0;
      pat         <= '0;
      len         <= '0;
      ovl         <= 1'b0;
      lim         <= '0;
      match_count <= '0;
      match_pulse <= 1'b0;
      cfg_err     <= 1'b0;
    end else begin
      match_pulse <= 1'b0;
      cfg_err     <= 1'b0;
      // Any cfg_load owns the cycle; an illegal one only raises cfg_err.
      if (cfg_load) begin
        if (cfg_ok) begin
          pat         <= cfg_pattern;
          len         <= cfg_len;
          ovl         <= cfg_overlap;
          lim         <= cfg_limit;
          hist        <= '0;
          fill        <= '0;
          idx         <= '0;
          match_count <= '0;
          state       <= S_ACCEPT;
        end else begin
          cfg_err <= 1'b1;
        end
      end else begin
        case (state)
          S_ACCEPT: begin
            if (in_valid) begin
              word  <= in_data;
              idx   <= '0;
              state <= S_SHIFT;
            end
          end
          S_SHIFT: begin
            hist <= hist_n;
            fill <= (hit && !ovl) ? 4'd0 : fill_n;
            word <= word << 1;
            idx  <= idx + IDX_W'(1);
            if (hit) begin
              match_pulse <= 1'b1;
              match_count <= cnt_inc;
            end
            if (lim_hit)       state <= S_HALT;
            else if (last_bit) state <= S_ACCEPT;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_seq_match_sched.sv
// Bench for seq_match_sched: directed scenarios plus random traffic, all checked
// every cycle against a bit-queue reference model.
module tb_seq_match_sched;
  localparam int WORD_W  = 8;
  localparam int PAT_MAX = 8;
  localparam int CNT_W   = 8;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               cfg_load = 1'b0;
  logic [PAT_MAX-1:0] cfg_pattern = '0;
  logic [3:0]         cfg_len = '0;
  logic               cfg_overlap = 1'b0;
  logic [CNT_W-1:0]   cfg_limit = '0;
  logic               in_valid = 1'b0;
  logic [WORD_W-1:0]  in_data = '0;
  logic               in_ready, match_pulse, busy, done, cfg_err;
  logic [CNT_W-1:0]   match_count;

  seq_match_sched #(.WORD_W(WORD_W), .PAT_MAX(PAT_MAX), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .cfg_load(cfg_load), .cfg_pattern(cfg_pattern),
    .cfg_len(cfg_len), .cfg_overlap(cfg_overlap), .cfg_limit(cfg_limit),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .match_pulse(match_pulse), .match_count(match_count), .busy(busy),
    .done(done), .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  // Reference model: mode 0 unconfigured, 1 waiting for a word, 2 scanning, 3 halted.
  int m_mode = 0;
  int m_len, m_pat, m_ovl, m_lim, m_cnt;
  bit m_pulse, m_err;
  bit pend[$];
  bit seen[$];

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s got %0d exp %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_cnt = 0; m_pulse = 0; m_err = 0;
    m_len = 0; m_pat = 0; m_ovl = 0; m_lim = 0;
    pend.delete(); seen.delete();
  endtask

  function automatic int seen_val();
    int v = 0;
    foreach (seen[i]) v = v * 2 + int'(seen[i]);
    return v;
  endfunction

  task automatic model_edge();
    bit b;
    m_pulse = 0;
    m_err   = 0;
    if (cfg_load) begin
      if (cfg_len >= 1 && cfg_len <= PAT_MAX) begin
        m_len = cfg_len; m_pat = cfg_pattern; m_ovl = cfg_overlap; m_lim = cfg_limit;
        m_cnt = 0; seen.delete(); pend.delete(); m_mode = 1;
      end else begin
        m_err = 1;
      end
    end else if (m_mode == 1) begin
      if (in_valid) begin
        for (int i = WORD_W - 1; i >= 0; i--) pend.push_back(in_data[i]);
        m_mode = 2;
      end
    end else if (m_mode == 2) begin
      b = pend.pop_front();
      seen.push_back(b);
      if (seen.size() > m_len) void'(seen.pop_front());
      if (seen.size() == m_len && seen_val() == (m_pat % (1 << m_len))) begin
        m_pulse = 1;
        if (m_cnt < (1 << CNT_W) - 1) m_cnt++;
        if (!m_ovl) seen.delete();
        if (m_lim != 0 && m_cnt == m_lim) begin
          m_mode = 3;
          pend.delete();
        end
      end
      if (m_mode == 2 && pend.size() == 0) m_mode = 1;
    end
  endtask

  task automatic check_all();
    chk("in_ready",    int'(in_ready),    int'(m_mode == 1));
    chk("busy",        int'(busy),        int'(m_mode == 2));
    chk("done",        int'(done),        int'(m_mode == 3));
    chk("match_pulse", int'(match_pulse), int'(m_pulse));
    chk("match_count", int'(match_count), m_cnt);
    chk("cfg_err",     int'(cfg_err),     int'(m_err));
  endtask

  task automatic step(input bit cl, input bit v, input logic [WORD_W-1:0] d);
    cfg_load = cl;
    in_valid = v;
    in_data  = d;
    @(posedge clk);
    model_edge();
    #1;
    check_all();
    cfg_load = 1'b0;
    in_valid = 1'b0;
  endtask

  task automatic load(input logic [PAT_MAX-1:0] p, input logic [3:0] l,
                      input bit o, input logic [CNT_W-1:0] lm);
    cfg_pattern = p; cfg_len = l; cfg_overlap = o; cfg_limit = lm;
    step(1'b1, 1'b0, '0);
  endtask

  task automatic send(input logic [WORD_W-1:0] d);
    step(1'b0, 1'b1, d);
    repeat (WORD_W) step(1'b0, 1'b0, '0);
  endtask

  initial begin
    int ready_at;
    model_reset();
    #12 rst = 1'b0;
    #1 check_all();

    // Reset mid-word, then no ready without a config.
    load(8'b101, 4'd3, 1'b1, '0);
    step(1'b0, 1'b1, 8'hA8);
    repeat (3) step(1'b0, 1'b0, '0);
    #3 rst = 1'b1;
    #1 model_reset();
    check_all();
    #1 rst = 1'b0;
    repeat (3) step(1'b0, 1'b1, 8'hFF);

    // Overlap, plus word throughput.
    load(8'b101, 4'd3, 1'b1, '0);
    step(1'b0, 1'b1, 8'b10101000);
    ready_at = 0;
    for (int i = 1; i <= 12 && ready_at == 0; i++) begin
      step(1'b0, 1'b0, '0);
      if (in_ready) ready_at = i + 1;
    end
    chk("ready_period", ready_at, WORD_W + 1);
    chk("ovl_count", int'(match_count), 2);

    // Non-overlap.
    load(8'b101, 4'd3, 1'b0, '0);
    send(8'b10101000);
    chk("novl_count", int'(match_count), 1);

    // Match spanning a word boundary.
    load(8'b101, 4'd3, 1'b1, '0);
    send(8'h01);
    chk("xword_first", int'(match_count), 0);
    send(8'h40);
    chk("xword_count", int'(match_count), 1);

    // Illegal lengths leave an accepting config in place.
    load('0, 4'd0, 1'b0, '0);
    load('0, 4'd9, 1'b0, '0);
    chk("err_keep_ready", int'(in_ready), 1);

    // Limit halts mid-word; illegal load keeps HALT; legal load restarts.
    load(8'b101, 4'd3, 1'b1, 8'd2);
    send(8'b10101010);
    chk("lim_count", int'(match_count), 2);
    chk("lim_done", int'(done), 1);
    load('0, 4'd15, 1'b0, '0);
    chk("halt_kept", int'(done), 1);
    load(8'b1, 4'd1, 1'b1, '0);
    chk("reload_count", int'(match_count), 0);

    // Counter saturation: 256 single-bit matches.
    repeat (32) send(8'hFF);
    chk("sat_count", int'(match_count), (1 << CNT_W) - 1);

    // Random traffic, including occasional illegal or mid-word loads.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 39) == 0) begin
        cfg_pattern = PAT_MAX'($urandom);
        cfg_len     = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(9, 15)) * 4'($urandom_range(0, 1))
                                                   : 4'($urandom_range(1, PAT_MAX));
        cfg_overlap = 1'($urandom);
        cfg_limit   = CNT_W'($urandom_range(0, 6));
        step(1'b1, 1'($urandom), WORD_W'($urandom));
      end else begin
        step(1'b0, 1'($urandom), WORD_W'($urandom));
      end
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
